// File: rtl/vrf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// vrf_wb_arbiter_if
//   Bundles the result-stream side (NrReq requesters) and the VRF write side
//   of the per-lane write-back arbiter.
//   Parameters: NrReq (requesters), DataW (VRF word width), AddrW (VRF word
//   address width), IdW (instruction id width). Strobe width is DataW/8.
//   Signals:
//     req_valid/req_wdata/req_wstrb/req_addr/req_id : per-requester result head
//     req_gnt   : one-hot pop back to the requester
//     vrf_we/vrf_wdata/vrf_wstrb/vrf_waddr/vrf_wid  : registered write to VRF
//     vrf_ready : VRF accepts the held write this cycle
//   Modports:
//     master : the environment (result buffers + vrf_accesser)
//     slave  : the arbiter
// ----------------------------------------------------------------------------
interface vrf_wb_arbiter_if #(
  parameter int unsigned NrReq = 3,
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 8,
  parameter int unsigned IdW   = 4
);
  localparam int unsigned StrbW = DataW / 8;

  logic [NrReq-1:0]            req_valid;
  logic [NrReq-1:0][DataW-1:0] req_wdata;
  logic [NrReq-1:0][StrbW-1:0] req_wstrb;
  logic [NrReq-1:0][AddrW-1:0] req_addr;
  logic [NrReq-1:0][IdW-1:0]   req_id;
  logic [NrReq-1:0]            req_gnt;

  logic             vrf_we;
  logic [DataW-1:0] vrf_wdata;
  logic [StrbW-1:0] vrf_wstrb;
  logic [AddrW-1:0] vrf_waddr;
  logic [IdW-1:0]   vrf_wid;
  logic             vrf_ready;

  modport master (
    output req_valid, req_wdata, req_wstrb, req_addr, req_id, vrf_ready,
    input  req_gnt, vrf_we, vrf_wdata, vrf_wstrb, vrf_waddr, vrf_wid
  );

  modport slave (
    input  req_valid, req_wdata, req_wstrb, req_addr, req_id, vrf_ready,
    output req_gnt, vrf_we, vrf_wdata, vrf_wstrb, vrf_waddr, vrf_wid
  );
endinterface

// File: rtl/vrf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// vrf_wb_arbiter
//   Shares the single per-lane VRF write port among NrReq functional-unit
//   result streams (index 0 = VALU). One valid requester is picked per cycle
//   by round-robin, popped through its grant, and its write is registered in a
//   one-entry output stage that drains when the VRF accepts it.
//   Ports:
//     clk_i            : clock
//     rst_i            : asynchronous reset, active-high
//     bus (slave)      : requester heads, grants, registered VRF write, ready
//     contention_cnt_o : cycles with at least one valid requester left ungranted
//   Optional feature: define VRF_WB_ARB_PERF_EN to build the saturating
//   contention counter; otherwise contention_cnt_o is tied to zero.
// ----------------------------------------------------------------------------
module vrf_wb_arbiter #(
  parameter int unsigned NrReq = 3,
  parameter int unsigned CntW  = 16,
  parameter int unsigned DataW = 32,
  parameter int unsigned AddrW = 8,
  parameter int unsigned IdW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vrf_wb_arbiter_if.slave   bus,
  output logic [CntW-1:0]   contention_cnt_o
);
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned PtrW  = $clog2(NrReq);

  logic             valid_q, valid_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [StrbW-1:0] wstrb_q, wstrb_d;
  logic [AddrW-1:0] waddr_q, waddr_d;
  logic [IdW-1:0]   wid_q, wid_d;

  logic             load_en;
  logic             found;
  logic             grant;
  logic [PtrW-1:0]  winner;

  // The output stage can take a new beat when empty or when it drains now.
  assign load_en = !valid_q || bus.vrf_ready;

  // Round-robin search starting at rr_ptr_q, wrapping modulo NrReq.
  always_comb begin : winner_search
    logic [PtrW:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int unsigned k = 0; k < NrReq; k++) begin
      sum = {1'b0, rr_ptr_q} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(NrReq)) begin
        sum = sum - (PtrW+1)'(NrReq);
      end
      if (!found && bus.req_valid[sum[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = sum[PtrW-1:0];
      end
    end
  end

  // Grants are forced low while reset is asserted so units never pop a beat
  // that the arbiter is about to discard.
  assign grant = found && load_en && !rst_i;

  generate
    for (genvar gi = 0; gi < NrReq; gi++) begin : g_req
      assign bus.req_gnt[gi] = grant && (winner == PtrW'(gi));

      // A waiting requester must keep presenting the same beat.
      req_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.req_valid[gi] && !bus.req_gnt[gi]) |=>
          (bus.req_valid[gi] && $stable(bus.req_wdata[gi]) &&
           $stable(bus.req_wstrb[gi]) && $stable(bus.req_addr[gi]) &&
           $stable(bus.req_id[gi])));
    end
  endgenerate

  always_comb begin : next_state
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    waddr_d  = waddr_q;
    wid_d    = wid_q;
    if (grant) begin
      valid_d  = 1'b1;
      wdata_d  = bus.req_wdata[winner];
      wstrb_d  = bus.req_wstrb[winner];
      waddr_d  = bus.req_addr[winner];
      wid_d    = bus.req_id[winner];
      rr_ptr_d = (winner == PtrW'(NrReq - 1)) ? '0 : winner + PtrW'(1);
    end else if (load_en) begin
      // Drained with nothing to refill: stage goes empty, payload is don't-care.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      waddr_q  <= '0;
      wid_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      waddr_q  <= waddr_d;
      wid_q    <= wid_d;
    end
  end

  assign bus.vrf_we    = valid_q;
  assign bus.vrf_wdata = wdata_q;
  assign bus.vrf_wstrb = wstrb_q;
  assign bus.vrf_waddr = waddr_q;
  assign bus.vrf_wid   = wid_q;

`ifdef VRF_WB_ARB_PERF_EN
  logic [CntW-1:0] cnt_q;
  logic            contended;

  // At most one count per cycle, however many requesters were passed over.
  assign contended = |(bus.req_valid & ~bus.req_gnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (contended && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign contention_cnt_o = cnt_q;
`else
  assign contention_cnt_o = '0;
`endif

endmodule
